// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit ALU datapath: default widths and opcode map.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int OP_WIDTH  = 4;

  localparam logic [OP_WIDTH-1:0] OP_NOP  = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'd1;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'd2;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 4'd3;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 4'd4;
  localparam logic [OP_WIDTH-1:0] OP_XOR  = 4'd5;
  localparam logic [OP_WIDTH-1:0] OP_INV  = 4'd6;
  localparam logic [OP_WIDTH-1:0] OP_SHL  = 4'd7;
  localparam logic [OP_WIDTH-1:0] OP_SHR  = 4'd8;
  localparam logic [OP_WIDTH-1:0] OP_LAST = 4'd8;

endpackage

// File: rtl/mux_sel_comb.sv
// Combinational opcode decode: picks one function-unit output and flags
// opcodes beyond the last defined one.
module mux_sel_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OP_W  = OP_WIDTH
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] nop_i,
  input  logic [WIDTH-1:0] add_i,
  input  logic [WIDTH-1:0] sub_i,
  input  logic [WIDTH-1:0] and_i,
  input  logic [WIDTH-1:0] or_i,
  input  logic [WIDTH-1:0] xor_i,
  input  logic [WIDTH-1:0] inv_i,
  input  logic [WIDTH-1:0] shl_i,
  input  logic [WIDTH-1:0] shr_i,
  output logic [WIDTH-1:0] sel_o,
  output logic             illegal_o
);

  always_comb begin
    sel_o     = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_NOP:  sel_o = nop_i;
      OP_ADD:  sel_o = add_i;
      OP_SUB:  sel_o = sub_i;
      OP_AND:  sel_o = and_i;
      OP_OR:   sel_o = or_i;
      OP_XOR:  sel_o = xor_i;
      OP_INV:  sel_o = inv_i;
      OP_SHL:  sel_o = shl_i;
      OP_SHR:  sel_o = shr_i;
      // Unused codes return zero so the zero flag stays meaningful.
      default: begin
        sel_o     = '0;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mux.sv
// Registered ALU result selector: one-cycle latency, zero/illegal flags and
// a valid strobe for writeback.
module mux
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OP_W  = OP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  opS,
  input  logic [WIDTH-1:0] nop_wire,
  input  logic [WIDTH-1:0] add_out,
  input  logic [WIDTH-1:0] sub_out,
  input  logic [WIDTH-1:0] and_out,
  input  logic [WIDTH-1:0] or_out,
  input  logic [WIDTH-1:0] xor_out,
  input  logic [WIDTH-1:0] invert_out,
  input  logic [WIDTH-1:0] shift_left_out,
  input  logic [WIDTH-1:0] shift_right_out,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             illegal_op
);

  logic [WIDTH-1:0] sel_val;
  logic             sel_illegal;

  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  mux_sel_comb #(
    .WIDTH (WIDTH),
    .OP_W  (OP_W)
  ) u_sel (
    .op_i      (opS),
    .nop_i     (nop_wire),
    .add_i     (add_out),
    .sub_i     (sub_out),
    .and_i     (and_out),
    .or_i      (or_out),
    .xor_i     (xor_out),
    .inv_i     (invert_out),
    .shl_i     (shift_left_out),
    .shr_i     (shift_right_out),
    .sel_o     (sel_val),
    .illegal_o (sel_illegal)
  );

  // Idle cycles hold the last result and flags; only the strobe drops.
  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    valid_d   = 1'b0;
    if (in_valid) begin
      result_d  = sel_val;
      zero_d    = (sel_val == '0);
      illegal_d = sel_illegal;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      valid_q   <= 1'b0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      valid_q   <= valid_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign result     = result_q;
  assign out_valid  = valid_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_mux.sv
// Self-checking bench for the registered ALU result selector.
module tb_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] opS;
  logic [7:0] d [9];
  logic [7:0] result;
  logic       out_valid, zero, illegal_op;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .opS             (opS),
    .nop_wire        (d[0]),
    .add_out         (d[1]),
    .sub_out         (d[2]),
    .and_out         (d[3]),
    .or_out          (d[4]),
    .xor_out         (d[5]),
    .invert_out      (d[6]),
    .shift_left_out  (d[7]),
    .shift_right_out (d[8]),
    .result          (result),
    .out_valid       (out_valid),
    .zero            (zero),
    .illegal_op      (illegal_op)
  );

  typedef struct {
    logic       valid;
    logic [3:0] op;
    logic [7:0] exp_res;
    logic       exp_zero;
    logic       exp_ill;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] er, input logic ez,
                           input logic ei, input logic eo);
    check({tag, ".result"},     32'(result),     32'(er));
    check({tag, ".zero"},       32'(zero),       32'(ez));
    check({tag, ".illegal_op"}, 32'(illegal_op), 32'(ei));
    check({tag, ".out_valid"},  32'(out_valid),  32'(eo));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_common();
    d[0] = 8'h00; d[1] = 8'h05; d[2] = 8'h01; d[3] = 8'h0F; d[4] = 8'hF0;
    d[5] = 8'hAA; d[6] = 8'h33; d[7] = 8'h02; d[8] = 8'h04;
  endtask

  task automatic randomize_data();
    for (int k = 0; k < 9; k++) d[k] = 8'($urandom);
  endtask

  function automatic void add_vec(logic v, logic [3:0] op, logic [7:0] r, logic z,
                                  logic il, logic ov);
    vec_t e;
    e.valid = v; e.op = op; e.exp_res = r; e.exp_zero = z; e.exp_ill = il; e.exp_ov = ov;
    vecs.push_back(e);
  endfunction

  // Reference model state: what the writeback stage should see.
  logic [7:0] m_res;
  logic       m_zero, m_ill, m_ov;

  initial begin
    logic [7:0] common [9];
    logic [7:0] sel;

    common = '{8'h00, 8'h05, 8'h01, 8'h0F, 8'hF0, 8'hAA, 8'h33, 8'h02, 8'h04};

    add_vec(1, 4'd1, 8'h05, 0, 0, 1);
    add_vec(1, 4'd4, 8'hF0, 0, 0, 1);
    add_vec(1, 4'd8, 8'h04, 0, 0, 1);
    for (int k = 0; k < 9; k++)
      add_vec(1, 4'(k), common[k], (common[k] == 8'h00), 0, 1);
    add_vec(1, 4'd9,  8'h00, 1, 1, 1);
    add_vec(1, 4'd15, 8'h00, 1, 1, 1);
    add_vec(1, 4'd1,  8'h05, 0, 0, 1);
    add_vec(1, 4'd5,  8'hAA, 0, 0, 1);
    add_vec(0, 4'd2,  8'hAA, 0, 0, 0);
    add_vec(0, 4'd12, 8'hAA, 0, 0, 0);
    add_vec(0, 4'd0,  8'hAA, 0, 0, 0);
    add_vec(1, 4'd3,  8'h0F, 0, 0, 1);

    // Reset with random inputs for two cycles
    rst = 1'b1;
    in_valid = 1'b1;
    opS = 4'($urandom);
    randomize_data();
    step();
    in_valid = 1'b0;
    opS = 4'($urandom);
    randomize_data();
    step();
    check_all("reset", 8'h00, 1'b1, 1'b0, 1'b0);

    rst = 1'b0;
    foreach (vecs[i]) begin
      if (vecs[i].valid) set_common(); else randomize_data();
      in_valid = vecs[i].valid;
      opS = vecs[i].op;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_zero,
                vecs[i].exp_ill, vecs[i].exp_ov);
    end

    // Reset coinciding with a valid op discards it
    set_common();
    in_valid = 1'b1;
    opS = 4'd3;
    rst = 1'b1;
    step();
    check_all("rst_mid", 8'h00, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_all("rst_release", 8'h0F, 1'b0, 1'b0, 1'b1);

    m_res = 8'h0F; m_zero = 1'b0; m_ill = 1'b0; m_ov = 1'b1;

    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 29) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      opS = 4'($urandom);
      randomize_data();
      if ($urandom_range(0, 7) == 0) d[opS <= 4'd8 ? opS : 4'd0] = 8'h00;
      if (rst) begin
        m_res = 8'h00; m_zero = 1'b1; m_ill = 1'b0; m_ov = 1'b0;
      end else if (in_valid) begin
        sel = (opS <= 4'd8) ? d[opS] : 8'h00;
        m_res = sel; m_zero = (sel == 8'h00); m_ill = (opS > 4'd8); m_ov = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
      step();
      check_all($sformatf("rnd%0d", c), m_res, m_zero, m_ill, m_ov);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
